// File: rtl/glom_unpack.sv
// glom_unpack: reassembles MSB-first bytes into a word and emits it with its glom byte
module glom_unpack #(
  parameter int WORD_BYTES = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_byte,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*WORD_BYTES-1:0] out_word,
  output logic [7:0]              out_glom,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        words_out
);
  localparam int W = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES);
  typedef enum logic {COLLECT, EMIT} state_t;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [W-1:0] new_word;
  logic accept, last, handoff;
  always_comb begin
    in_ready = state == COLLECT;
    out_valid = state == EMIT;
    accept = in_valid && in_ready;
    last = accept && cnt == CW'(WORD_BYTES - 1);
    handoff = out_valid && out_ready;
    new_word = {out_word[W-9:0], in_byte};
    next_state = last ? EMIT : handoff ? COLLECT : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= COLLECT;
      cnt <= '0;
      out_word <= '0;
      out_glom <= '0;
      words_out <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        out_word <= new_word;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (last) out_glom <= {new_word[W-1:W-4], in_byte[3:0]};
      if (handoff) words_out <= words_out + 1'b1;
    end
  end
endmodule

// File: tb/tb_glom_unpack.sv
// tb_glom_unpack: scoreboard bench for glom_unpack (WORD_BYTES=4, CNT_W=2 to exercise wrap)
module tb_glom_unpack;
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_byte = 0;
  logic in_ready, out_valid;
  logic [31:0] out_word;
  logic [7:0] out_glom;
  logic [1:0] words_out;
  int checks = 0, errors = 0, cyc = 0;
  logic [39:0] sb[$];
  logic [31:0] mword;
  int mn;
  logic [1:0] exp_cnt;

  glom_unpack #(.WORD_BYTES(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_word(out_word), .out_glom(out_glom), .out_valid(out_valid), .out_ready(out_ready),
    .words_out(words_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    sb.delete();
    mword = 0;
    mn = 0;
    exp_cnt = 0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    mword = {mword[23:0], b};
    mn++;
    if (mn == 4) begin
      sb.push_back({mword, mword[31:28], b[3:0]});
      mn = 0;
    end
  endtask

  task automatic do_reset();
    reset = 0;
    tick();
    reset = 1;
    model_clear();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1;
    in_byte = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    model_accept(b);
    in_valid = 0;
  endtask

  task automatic recv(input string name);
    logic [39:0] e;
    int n = 0;
    out_ready = 1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!out_valid || sb.size() == 0) begin
      errors++;
      $display("FAIL %s_wait: out_valid=%0b queued=%0d required valid with word queued", name, out_valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (out_word !== e[39:8] || out_glom !== e[7:0]) begin
        errors++;
        $display("FAIL %s_data: word=%h glom=%h required word=%h glom=%h", name, out_word, out_glom, e[39:8], e[7:0]);
      end
    end
    tick();
    out_ready = 0;
    exp_cnt++;
    checks++;
    if (words_out !== exp_cnt || out_valid !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL %s_handoff: words_out=%0d out_valid=%0b in_ready=%0b required %0d 0 1", name, words_out, out_valid, in_ready, exp_cnt);
    end
  endtask

  task automatic test_reset();
    in_byte = 8'hFF;
    in_valid = 1;
    reset = 0;
    tick();
    tick();
    in_valid = 0;
    reset = 1;
    model_clear();
    checks++;
    if (out_valid !== 0 || in_ready !== 1 || out_word !== 0 || out_glom !== 0 || words_out !== 0) begin
      errors++;
      $display("FAIL reset: valid=%0b ready=%0b word=%h glom=%h cnt=%0d required 0 1 0 0 0", out_valid, in_ready, out_word, out_glom, words_out);
    end
  endtask

  task automatic test_basic();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    checks++;
    if (out_valid !== 1 || out_word !== 32'h12345678 || out_glom !== 8'h18) begin
      errors++;
      $display("FAIL basic_latency: valid=%0b word=%h glom=%h required 1 12345678 18", out_valid, out_word, out_glom);
    end
    recv("basic");
  endtask

  task automatic test_backpressure();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    in_valid = 1;
    in_byte = 8'hAB;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (in_ready !== 0 || out_valid !== 1 || out_word !== 32'h12345678 || out_glom !== 8'h18) begin
        errors++;
        $display("FAIL bp_hold%0d: ready=%0b valid=%0b word=%h glom=%h required 0 1 12345678 18", i, in_ready, out_valid, out_word, out_glom);
      end
      tick();
    end
    recv("bp");
    tick();
    model_accept(8'hAB);
    in_valid = 0;
    send_byte(8'hCD);
    send_byte(8'hEF);
    send_byte(8'h01);
    recv("bp_next");
  endtask

  task automatic test_gapped();
    logic [7:0] bytes[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i]);
      if (i < 3)
        for (int g = 0; g < 3; g++) begin
          checks++;
          if (out_valid !== 0) begin
            errors++;
            $display("FAIL gap_early_valid: out_valid=%0b required 0", out_valid);
          end
          tick();
        end
    end
    checks++;
    if (out_word !== 32'hDEADBEEF || out_glom !== 8'hDF) begin
      errors++;
      $display("FAIL gap_word: word=%h glom=%h required deadbeef df", out_word, out_glom);
    end
    recv("gap");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    send_byte(8'hCA);
    send_byte(8'hFE);
    send_byte(8'hBA);
    send_byte(8'hBE);
    checks++;
    if (out_word !== 32'hCAFEBABE || out_glom !== 8'hCE) begin
      errors++;
      $display("FAIL rmid_word: word=%h glom=%h required cafebabe ce", out_word, out_glom);
    end
    recv("rmid");
  endtask

  task automatic test_reset_emit();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    tick();
    do_reset();
    checks++;
    if (out_valid !== 0 || words_out !== 0 || in_ready !== 1) begin
      errors++;
      $display("FAIL remit: valid=%0b words_out=%0d ready=%0b required 0 0 1", out_valid, words_out, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, hand = 0, last_h = -1;
    bit ho;
    logic [39:0] e;
    do_reset();
    out_ready = 1;
    in_valid = 1;
    for (int c = 0; c < 60 && hand < 5; c++) begin
      in_byte = 8'(8'h10 * (acc / 4 + 1) + acc % 4);
      ho = out_valid && out_ready;
      if (in_ready) begin
        model_accept(in_byte);
        acc++;
      end
      if (ho) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected: word=%h with empty scoreboard", out_word);
        end else begin
          e = sb.pop_front();
          if (out_word !== e[39:8] || out_glom !== e[7:0]) begin
            errors++;
            $display("FAIL b2b_data: word=%h glom=%h required %h %h", out_word, out_glom, e[39:8], e[7:0]);
          end
        end
      end
      tick();
      if (ho) begin
        exp_cnt++;
        hand++;
        checks++;
        if (words_out !== exp_cnt) begin
          errors++;
          $display("FAIL b2b_count%0d: words_out=%0d required %0d", hand, words_out, exp_cnt);
        end
        if (last_h >= 0) begin
          checks++;
          if (cyc - last_h != 5) begin
            errors++;
            $display("FAIL b2b_rate: %0d cycles per word required 5", cyc - last_h);
          end
        end
        last_h = cyc;
      end
    end
    in_valid = 0;
    out_ready = 0;
    checks++;
    if (hand != 5) begin
      errors++;
      $display("FAIL b2b_timeout: %0d handoffs required 5", hand);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_backpressure();
    test_gapped();
    test_reset_mid();
    test_reset_emit();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/glom_unpack.md
Name: glom_unpack

Overview:
- Receiving end of the packed-byte path: collects a stream of 8-bit bytes and reassembles them, MSB byte first, into one WORD_BYTES-byte word.
- Emits the reassembled word together with its glom field: the top nibble and bottom nibble concatenated into one byte.
- Sits downstream of the byte producer. Its glom output must match the glom stage applied directly to the same word.
- Runs as a two-state FSM with valid/ready handshakes on both sides.

Parameters:
- WORD_BYTES, 4, bytes per assembled word (legal range 2..8).
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- in_byte  input  8  incoming packed byte.
- in_valid  input  1  in_byte is valid this cycle.
- in_ready  output  1  block accepts in_byte this cycle.
- out_word  output  8*WORD_BYTES  reassembled word; first-received byte in the MSBs.
- out_glom  output  8  { out_word[MSB:MSB-3], out_word[3:0] }.
- out_valid  output  1  out_word and out_glom hold a complete word.
- out_ready  input  1  consumer takes the word this cycle.
- words_out  output  CNT_W  count of words handed off.

Behaviour:
- Reset (reset==0 at posedge): fsmState=__Collect, byte count=0, out_word=0, out_glom=0, out_valid=0, words_out=0. Reset wins over every other event.
- Reset mid-word discards all partially collected bytes. Reset during __Emit drops the pending word; it is neither counted nor presented again.
- State __Collect:
  - in_ready=1, out_valid=0.
  - A byte is accepted on a posedge where in_valid && in_ready.
  - On accept: out_word <= {out_word[8*WORD_BYTES-9:0], in_byte}; count <= count+1.
  - When the accepted byte is number WORD_BYTES (count==WORD_BYTES-1), in the same edge: out_glom <= { new word top nibble, in_byte[3:0] }, count <= 0, fsmState <= __Emit.
  - in_valid==0 leaves all state unchanged. Gaps between bytes are allowed, with no timeout.
- State __Emit:
  - out_valid=1, in_ready=0.
  - out_word and out_glom are held stable.
  - On posedge with out_ready==1: words_out <= words_out+1 (wraps at 2^CNT_W to 0), fsmState <= __Collect.
  - out_ready==0 holds indefinitely.
  - in_valid during __Emit is ignored; the producer must hold the byte until in_ready returns.
- Latency: out_valid rises on the cycle after the posedge that accepts the last byte.
- Throughput:
  - Minimum WORD_BYTES+1 cycles per word: WORD_BYTES accepts plus 1 handoff.
  - in_ready returns to 1 on the cycle after the handoff edge.
  - No simultaneous accept-and-emit.
- in_ready and out_valid are decoded from fsmState only and have no combinational path from inputs.
- out_word retains the last word after handoff. During collection it shifts, so it is not meaningful while out_valid==0.
- Unused states decode to __Collect with count=0.

Test Plan:
- Basic reassembly: reset low 2 cycles, then in_valid=1 with bytes 0x12,0x34,0x56,0x78 on consecutive cycles, out_ready=1 -> out_valid=1 one cycle after 0x78 accepted, out_word=0x12345678, out_glom=0x18, words_out=1 after the handoff edge.
- Backpressure: as above but out_ready=0 for 10 cycles while in_valid=1 presents 0xAB -> in_ready=0, out_word stays 0x12345678, out_glom stays 0x18. Raise out_ready -> handoff; 0xAB accepted the next cycle.
- Gapped input: bytes 0xDE,0xAD,0xBE,0xEF separated by 3-cycle in_valid=0 gaps -> out_word=0xDEADBEEF, out_glom=0xDF, no early out_valid.
- Reset mid-word: send 0x11,0x22, assert reset low 1 cycle, then send 0xCA,0xFE,0xBA,0xBE -> out_word=0xCAFEBABE, out_glom=0xCE, words_out=1.
- Reset in __Emit: complete 0x01020304 with out_ready=0, pulse reset -> out_valid=0 the next cycle, words_out=0.
- Counter wrap: CNT_W=2, stream 5 words back-to-back with out_ready=1 -> words_out sequence 1,2,3,0,1; throughput exactly 5 cycles per word.
